// File: rtl/data_mem_pkg.sv
// Shared core definitions: load/store width encodings, funct3/opcode constants, MMIO address,
// and the lane steering / load extension helpers used by the data memory responder.
package data_mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [31:0] MMIO_ADDR_DEF = 32'hFFFF_FF00;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            W_BYTE:  return 1'b0;
            W_HALF:  return off[0];
            W_WORD:  return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] off);
        case (width)
            W_BYTE:  return 4'b0001 << off;
            W_HALF:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data so every enabled lane sees its bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] wdata);
        case (width)
            W_BYTE:  return {4{wdata[7:0]}};
            W_HALF:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] width, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  return {{24{~uns & b[7]}}, b};
            W_HALF:  return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32, per-byte write enables, read-before-write.
// Read data updates only on re and is held otherwise; contents are never reset.
module ram_sp_be #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data memory responder: lane-steered stores, extended loads valid one cycle after read_i, MMIO reg.
// No backpressure: every strobed request completes at the edge it is presented.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_ADDR  = MMIO_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_ro,
    output logic        rvalid_ro,
    output logic        misalign_ro,
    output logic [31:0] mmio_ro,
    output logic        mmio_we_ro
);

    logic        bad;
    logic        is_mmio;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] be_mask;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    logic        ld_zero;
    logic        ld_mmio;
    logic [1:0]  ld_off;
    logic [1:0]  ld_width;
    logic        ld_uns;
    logic [31:0] mmio_snap;

    assign bad     = misaligned(width_i, addr_i[1:0]);
    assign is_mmio = addr_i[31:2] == MMIO_ADDR[31:2];
    assign be      = store_be(width_i, addr_i[1:0]);
    assign lanes   = store_lanes(width_i, wdata_i);
    assign be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    // Gating with rst keeps a request that overlaps reset from landing half-done in the RAM.
    assign ram_we = (!rst && write_i && !bad && !is_mmio) ? be : 4'b0000;

    ram_sp_be #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_i[ADDR_WIDTH+1:2]),
        .re    (read_i && !rst),
        .we    (ram_we),
        .wdata (lanes),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_ro   <= 1'b0;
            misalign_ro <= 1'b0;
            mmio_we_ro  <= 1'b0;
            mmio_ro     <= '0;
            ld_zero     <= 1'b1;
            ld_mmio     <= 1'b0;
            ld_off      <= 2'b00;
            ld_width    <= W_WORD;
            ld_uns      <= 1'b0;
            mmio_snap   <= '0;
        end else begin
            rvalid_ro   <= read_i;
            misalign_ro <= (read_i || write_i) && bad;
            mmio_we_ro  <= write_i && !bad && is_mmio;
            if (write_i && !bad && is_mmio) begin
                mmio_ro <= (mmio_ro & ~be_mask) | (lanes & be_mask);
            end
            // Load attributes are only captured on a read so rdata_ro holds between reads.
            if (read_i) begin
                ld_zero   <= bad;
                ld_mmio   <= is_mmio;
                ld_off    <= addr_i[1:0];
                ld_width  <= width_i;
                ld_uns    <= unsigned_i;
                mmio_snap <= mmio_ro;
            end
        end
    end

    // Extension works on registered state only; nothing here depends on the current inputs.
    assign rdata_ro = ld_zero ? 32'h0
                    : load_extend(ld_mmio ? mmio_snap : ram_rdata, ld_off, ld_width, ld_uns);

endmodule

// File: tb/tb_data_mem.sv
// Directed plus randomized bench for data_mem against a byte-array reference model.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        write_i;
    logic        read_i;
    logic [1:0]  width_i;
    logic        unsigned_i;
    logic [31:0] rdata_ro;
    logic        rvalid_ro;
    logic        misalign_ro;
    logic [31:0] mmio_ro;
    logic        mmio_we_ro;

    always #5 clk = ~clk;

    data_mem dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .write_i     (write_i),
        .read_i      (read_i),
        .width_i     (width_i),
        .unsigned_i  (unsigned_i),
        .rdata_ro    (rdata_ro),
        .rvalid_ro   (rvalid_ro),
        .misalign_ro (misalign_ro),
        .mmio_ro     (mmio_ro),
        .mmio_we_ro  (mmio_we_ro)
    );

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    int checks = 0;
    int errors = 0;

    // Reference model: RAM as 16 KiB of bytes, plus expected output state.
    logic [7:0]  mb [0:16383];
    logic [31:0] m_mmio  = '0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0;
    logic        m_mis = 1'b0;
    logic        m_mwe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit wr, input bit rd, input logic [1:0] w, input bit u,
                         input logic [31:0] a, input logic [31:0] d);
        bit          bad;
        bit          mm;
        int          n;
        int          idx;
        int          off;
        logic [31:0] v;
        bad = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
        mm  = (a[31:2] == MMIO[31:2]);
        n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        idx = int'(a[13:0]);
        off = int'(a[1:0]);
        if (rd) begin
            v = 32'h0;
            if (!bad) begin
                for (int k = 0; k < n; k++)
                    v = v | (32'(mm ? m_mmio[8*(off+k) +: 8] : mb[idx+k]) << (8*k));
                if (!u && n < 4 && v[8*n-1])
                    v = v | ~((32'h1 << (8*n)) - 32'h1);
            end
            m_rdata = v;
        end
        m_rvalid = rd;
        m_mis    = (rd || wr) && bad;
        m_mwe    = wr && !bad && mm;
        if (wr && !bad) begin
            for (int k = 0; k < n; k++) begin
                if (mm) m_mmio[8*(off+k) +: 8] = d[8*k +: 8];
                else    mb[idx+k] = d[8*k +: 8];
            end
        end
    endtask

    task automatic step(input string tag, input bit wr, input bit rd, input logic [1:0] w,
                        input bit u, input logic [31:0] a, input logic [31:0] d);
        write_i    = wr;
        read_i     = rd;
        width_i    = w;
        unsigned_i = u;
        addr_i     = a;
        wdata_i    = d;
        model(wr, rd, w, u, a, d);
        @(posedge clk);
        #1;
        chk({tag, "_rdata"},  rdata_ro,          m_rdata);
        chk({tag, "_rvalid"}, 32'(rvalid_ro),    32'(m_rvalid));
        chk({tag, "_mis"},    32'(misalign_ro),  32'(m_mis));
        chk({tag, "_mmio"},   mmio_ro,           m_mmio);
        chk({tag, "_mmiowe"}, 32'(mmio_we_ro),   32'(m_mwe));
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          kind;

        for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
        rst = 1'b1; addr_i = '0; wdata_i = '0; write_i = 1'b0; read_i = 1'b0;
        width_i = 2'b10; unsigned_i = 1'b0;
        #1;
        chk("rst_rdata", rdata_ro, 32'h0);
        chk("rst_rvalid", 32'(rvalid_ro), 32'h0);
        chk("rst_mis", 32'(misalign_ro), 32'h0);
        chk("rst_mmio", mmio_ro, 32'h0);
        chk("rst_mmiowe", 32'(mmio_we_ro), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed sequence.
        step("sw10", 1, 0, 2'd2, 0, 32'h10, 32'h12345678);
        step("lw10", 0, 1, 2'd2, 0, 32'h10, 0);
        chk("plan_lw10", rdata_ro, 32'h12345678);
        chk("plan_lw10_v", 32'(rvalid_ro), 32'h1);
        step("lbu11", 0, 1, 2'd0, 1, 32'h11, 0);
        chk("plan_lbu11", rdata_ro, 32'h00000056);
        step("lh12", 0, 1, 2'd1, 0, 32'h12, 0);
        chk("plan_lh12", rdata_ro, 32'h00001234);
        step("lh10", 0, 1, 2'd1, 0, 32'h10, 0);
        chk("plan_lh10", rdata_ro, 32'h00005678);
        step("sb12", 1, 0, 2'd0, 0, 32'h12, 32'h000000AB);
        step("lw10b", 0, 1, 2'd2, 0, 32'h10, 0);
        chk("plan_lw10b", rdata_ro, 32'h12AB5678);
        step("lb12", 0, 1, 2'd0, 0, 32'h12, 0);
        chk("plan_lb12", rdata_ro, 32'hFFFFFFAB);
        step("idle", 0, 0, 2'd0, 0, 32'h0, 0);
        chk("plan_hold", rdata_ro, 32'hFFFFFFAB);
        step("sw11", 1, 0, 2'd2, 0, 32'h11, 32'hDEADBEEF);
        chk("plan_sw11_mis", 32'(misalign_ro), 32'h1);
        step("lw10c", 0, 1, 2'd2, 0, 32'h10, 0);
        chk("plan_lw10c", rdata_ro, 32'h12AB5678);
        chk("plan_mis_pulse", 32'(misalign_ro), 32'h0);
        step("lh13", 0, 1, 2'd1, 0, 32'h13, 0);
        chk("plan_lh13_mis", 32'(misalign_ro), 32'h1);
        chk("plan_lh13_rd", rdata_ro, 32'h0);
        step("sw3f00", 1, 0, 2'd2, 0, 32'h3F00, 32'hCAFEF00D);
        step("sbmmio", 1, 0, 2'd0, 0, MMIO, 32'h00000041);
        chk("plan_mmio", mmio_ro, 32'h00000041);
        chk("plan_mmiowe", 32'(mmio_we_ro), 32'h1);
        step("lw3f00", 0, 1, 2'd2, 0, 32'h3F00, 0);
        chk("plan_alias", rdata_ro, 32'hCAFEF00D);
        chk("plan_mmiowe_end", 32'(mmio_we_ro), 32'h0);
        step("lwmmio", 0, 1, 2'd2, 0, MMIO, 0);
        chk("plan_lwmmio", rdata_ro, 32'h00000041);
        step("rbw", 1, 1, 2'd2, 0, 32'h3F00, 32'h01020304);
        chk("plan_rbw", rdata_ro, 32'hCAFEF00D);
        step("lw3f00b", 0, 1, 2'd2, 0, 32'h3F00, 0);
        chk("plan_after_rbw", rdata_ro, 32'h01020304);

        // Reset in the middle of a load request.
        step("lw10d", 0, 1, 2'd2, 0, 32'h10, 0);
        read_i = 1'b1; width_i = 2'd2; addr_i = 32'h10;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rdata", rdata_ro, 32'h0);
        chk("mid_rst_rvalid", 32'(rvalid_ro), 32'h0);
        chk("mid_rst_mmio", mmio_ro, 32'h0);
        @(posedge clk); #1;
        read_i = 1'b0; rst = 1'b0;
        m_rdata = '0; m_rvalid = 1'b0; m_mis = 1'b0; m_mwe = 1'b0; m_mmio = '0;
        step("lw10e", 0, 1, 2'd2, 0, 32'h10, 0);
        chk("plan_retained", rdata_ro, 32'h12AB5678);

        // Preload bytes 0..255 so every randomized read hits known data.
        for (int i = 0; i < 64; i++)
            step("pre", 1, 0, 2'd2, 0, 32'(i * 4), $urandom);

        for (int i = 0; i < 500; i++) begin
            r    = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0) a = {30'h3FFFFFC0, r[1:0]};
            else           a = {r[31:14], 6'b0, r[7:0]};
            case ($urandom_range(0, 7))
                0, 1, 2: step("rnd_wr", 1, 0, 2'($urandom_range(0, 3)), 0, a, $urandom);
                3, 4, 5: step("rnd_rd", 0, 1, 2'($urandom_range(0, 3)), r[8], a, 0);
                6:       step("rnd_rw", 1, 1, 2'($urandom_range(0, 3)), r[8], a, $urandom);
                default: step("rnd_idle", 0, 0, 2'd0, 0, a, $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
